// File: rtl/spi_slave_rx_if.sv
// Pin and word-port bundle for the oversampling SPI receive block.
// Word port: a word moves on every clk edge where dout_valid & dout_ready are both 1; dout holds while dout_valid=1 and no transfer occurs.
interface spi_slave_rx_if #(
  parameter int DATA_W = 12
);
  logic              sclk;
  logic              mosi;
  logic              cs;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              frame_err;
  logic              overflow;
  logic              busy;
  logic [1:0]        dbg_state;

  modport slave (
    input  sclk, mosi, cs, dout_ready,
    output dout, dout_valid, frame_err, overflow, busy, dbg_state
  );

  modport master (
    output sclk, mosi, cs, dout_ready,
    input  dout, dout_valid, frame_err, overflow, busy, dbg_state
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI receive side: oversamples sclk/mosi/cs on clk, shifts one LSB-first word per cs-low frame
// and offers it through a one-word holding register.
module spi_slave_rx #(
  parameter int DATA_W      = 12,
  parameter int LEAD_EDGES  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_slave_rx_if.slave  bus
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int LW = (LEAD_EDGES < 1) ? 1 : $clog2(LEAD_EDGES + 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, WAIT_CS} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q, fill_q;
  logic                   sclk_dly_q, cs_dly_q, armed_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_fall, cs_fall, cs_rise;

  state_e            state_q, state_d;
  logic [LW-1:0]     lead_q, lead_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              extra_q, extra_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic              busy_q;
  logic              deliver, accept;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_dly_q & ~sclk_s;
  assign cs_fall   = cs_dly_q & ~cs_s;
  assign cs_rise   = ~cs_dly_q & cs_s;

  // fill_q marks when the last sync stage holds a real pin sample rather than the
  // reset value, so a reset in the middle of a frame cannot arm the receiver.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '1;
      mosi_sync_q <= '1;
      cs_sync_q   <= '1;
      sclk_dly_q  <= 1'b1;
      cs_dly_q    <= 1'b1;
      fill_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
    end
  end

  always_comb begin
    state_d     = state_q;
    lead_d      = lead_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    extra_d     = extra_q;
    frame_err_d = 1'b0;
    deliver     = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          lead_d  = '0;
          bit_d   = '0;
          shift_d = '0;
          extra_d = 1'b0;
          state_d = (LEAD_EDGES == 0) ? SHIFT : LEAD;
        end
      end
      LEAD: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_fall) begin
          lead_d = lead_q + 1'b1;
          if (lead_d == LW'(LEAD_EDGES)) state_d = SHIFT;
        end
      end
      SHIFT: begin
        // cs_rise outranks a coincident sclk_fall: the frame ends, no sample taken.
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end else if (sclk_fall) begin
          shift_d[bit_q] = mosi_s;
          bit_d          = bit_q + 1'b1;
          if (bit_d == BW'(DATA_W)) state_d = WAIT_CS;
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          if (extra_q) frame_err_d = 1'b1;
          else         deliver     = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall) begin
          extra_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept       = dout_valid_q & bus.dout_ready;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q & ~accept;
    overflow_d   = 1'b0;
    if (deliver) begin
      if (!dout_valid_q || accept) begin
        dout_d       = shift_q;
        dout_valid_d = 1'b1;
      end else begin
        overflow_d   = 1'b1;
        dout_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lead_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      extra_q      <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lead_q       <= lead_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      extra_q      <= extra_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state_q;
endmodule
